// File: rtl/modport_dut_if.sv
// APB signal bundle between a bus master and the modport_dut register slave.
interface modport_dut_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/modport_dut.sv
// APB slave with a NUM_REGS x DATA_WIDTH register file and programmable wait states.
// PREADY, PSLVERR and PRDATA are all registered and pulse together for one cycle per transfer.
module modport_dut #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 1
) (
  input logic          PCLK,
  input logic          PRESETn,
  modport_dut_if.slave bus
);
  localparam int         IDX_W     = $clog2(NUM_REGS);
  localparam logic [3:0] WAIT_LAST = (WAIT_STATES >= 2) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            wait_cnt;
  logic                  pready;
  logic                  pslverr;
  logic [DATA_WIDTH-1:0] prdata;

  logic                  capture;
  logic                  complete;
  logic                  pready_next;
  logic                  pslverr_next;
  logic [DATA_WIDTH-1:0] prdata_next;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic                  eff_write;
  logic                  eff_err;
  logic                  q_err;
  logic [IDX_W-1:0]      eff_idx;
  logic [IDX_W-1:0]      q_idx;

  function automatic logic addr_error(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> (IDX_W + 2)) != '0);
  endfunction

  // The response is computed on the edge that raises PREADY; with zero wait states
  // that is the capture edge itself, so the live bus fields are used there.
  assign eff_addr  = capture ? bus.PADDR : addr_q;
  assign eff_write = capture ? bus.PWRITE : write_q;
  assign eff_err   = addr_error(eff_addr);
  assign eff_idx   = eff_addr[IDX_W+1:2];
  assign q_err     = addr_error(addr_q);
  assign q_idx     = addr_q[IDX_W+1:2];

  assign bus.PREADY  = pready;
  assign bus.PSLVERR = pslverr;
  assign bus.PRDATA  = prdata;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          state_next = SETUP;
          capture    = 1'b1;
        end
      end
      SETUP, ACCESS: begin
        if (!bus.PSEL) begin
          state_next = IDLE;
        end else if (pready) begin
          complete = 1'b1;
          if (!bus.PENABLE) begin
            state_next = SETUP;
            capture    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (state == SETUP) begin
          state_next = ACCESS;
        end else if (!bus.PENABLE) begin
          // Master restarted mid-access: drop the old transfer and take the new setup.
          state_next = SETUP;
          capture    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pready_next = 1'b0;
    if (capture && WAIT_STATES == 0)
      pready_next = 1'b1;
    else if (state == SETUP && state_next == ACCESS && WAIT_STATES == 1)
      pready_next = 1'b1;
    else if (state == ACCESS && state_next == ACCESS && WAIT_STATES >= 2 && wait_cnt == WAIT_LAST)
      pready_next = 1'b1;
    pslverr_next = pready_next && eff_err;
    prdata_next  = '0;
    if (pready_next && !eff_err && !eff_write)
      prdata_next = regs[eff_idx];
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      wait_cnt <= 4'd0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      prdata   <= '0;
    end else begin
      if (capture) begin
        addr_q  <= bus.PADDR;
        write_q <= bus.PWRITE;
        wdata_q <= bus.PWDATA;
      end
      if (state == SETUP && state_next == ACCESS)
        wait_cnt <= 4'd1;
      else if (state == ACCESS && state_next == ACCESS)
        wait_cnt <= wait_cnt + 4'd1;
      pready  <= pready_next;
      pslverr <= pslverr_next;
      prdata  <= prdata_next;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (complete && write_q && !q_err) begin
      regs[q_idx] <= wdata_q;
    end
  end
endmodule

// File: tb/tb_modport_dut.sv
// Directed bench driving three modport_dut instances (1, 0 and 3 wait states) over APB.
module tb_modport_dut;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        m_psel    [3];
  logic        m_penable [3];
  logic        m_pwrite  [3];
  logic [31:0] m_paddr   [3];
  logic [31:0] m_pwdata  [3];
  logic        s_ready   [3];
  logic        s_err     [3];
  logic [31:0] s_rdata   [3];

  int tests_run    = 0;
  int tests_failed = 0;

  modport_dut_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    assign bus[g].PSEL    = m_psel[g];
    assign bus[g].PENABLE = m_penable[g];
    assign bus[g].PWRITE  = m_pwrite[g];
    assign bus[g].PADDR   = m_paddr[g];
    assign bus[g].PWDATA  = m_pwdata[g];
    assign s_ready[g]     = bus[g].PREADY;
    assign s_err[g]       = bus[g].PSLVERR;
    assign s_rdata[g]     = bus[g].PRDATA;
    modport_dut #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(WS)) u_dut (
      .PCLK   (clk),
      .PRESETn(rst_n),
      .bus    (bus[g])
    );
  end

  function automatic int waitOf(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic setBus(input int d, input logic sel, input logic en, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd);
    m_psel[d]    = sel;
    m_penable[d] = en;
    m_pwrite[d]  = wr;
    m_paddr[d]   = a;
    m_pwdata[d]  = wd;
  endtask

  // One APB transfer starting now (just after a rising edge); b2b leaves the bus
  // selected so the next call issues its setup with no idle cycle in between.
  task automatic applyStimulus(input int d, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit b2b, input bit mangle,
                               input logic [31:0] exp_rdata, input bit exp_err, input string tag);
    int          cyc;
    int          bad;
    bit          seen;
    logic [31:0] rdata;
    logic        err;
    cyc   = 1;
    bad   = 0;
    seen  = 1'b0;
    rdata = '0;
    err   = 1'b0;
    setBus(d, 1'b1, 1'b0, wr, addr, wdata);
    while (!seen && cyc <= 20) begin
      @(negedge clk);
      if (s_ready[d] === 1'b1) begin
        seen  = 1'b1;
        rdata = s_rdata[d];
        err   = s_err[d];
      end else begin
        if (s_err[d] !== 1'b0 || s_rdata[d] !== 32'h0) bad++;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == 2) setBus(d, 1'b1, 1'b1, wr, addr, wdata);
        if (cyc == 3 && mangle) setBus(d, 1'b1, 1'b1, !wr, addr ^ 32'h4, ~wdata);
      end
    end
    checkOutput({tag, "_lat"}, seen ? 32'(cyc) : 32'd0, 32'(2 + waitOf(d)));
    checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
    if (!wr || exp_err) checkOutput({tag, "_rdata"}, rdata, exp_rdata);
    checkOutput({tag, "_quiet"}, 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    if (!b2b) begin
      setBus(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput({tag, "_once"}, 32'(s_ready[d]), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int ones;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) setBus(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset_ready%0d", d), 32'(s_ready[d]), 32'd0);
      checkOutput($sformatf("reset_err%0d", d), 32'(s_err[d]), 32'd0);
      checkOutput($sformatf("reset_rdata%0d", d), s_rdata[d], 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // One wait state: basic access, errors, back-to-back.
    applyStimulus(0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, "w1_rd00");
    applyStimulus(0, 1'b1, 32'h3C, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0, "w1_wr3c");
    applyStimulus(0, 1'b0, 32'h3C, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0, "w1_rd3c");
    applyStimulus(0, 1'b1, 32'h40, 32'h12345678, 1'b0, 1'b0, 32'h0,        1'b1, "w1_wr40");
    applyStimulus(0, 1'b1, 32'h05, 32'h12345678, 1'b0, 1'b0, 32'h0,        1'b1, "w1_wr05");
    applyStimulus(0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, "w1_rd00b");
    applyStimulus(0, 1'b0, 32'h04, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, "w1_rd04");
    applyStimulus(0, 1'b1, 32'h04, 32'h1,        1'b1, 1'b0, 32'h0,        1'b0, "w1_b2b04");
    applyStimulus(0, 1'b1, 32'h08, 32'h2,        1'b0, 1'b0, 32'h0,        1'b0, "w1_b2b08");
    applyStimulus(0, 1'b0, 32'h04, 32'h0,        1'b1, 1'b0, 32'h1,        1'b0, "w1_rd04b");
    applyStimulus(0, 1'b0, 32'h08, 32'h0,        1'b0, 1'b0, 32'h2,        1'b0, "w1_rd08");

    // Zero wait states.
    applyStimulus(1, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, "w0_rd00");
    applyStimulus(1, 1'b1, 32'h08, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0,        1'b0, "w0_wr08");
    applyStimulus(1, 1'b0, 32'h08, 32'h0,        1'b1, 1'b0, 32'hCAFEF00D, 1'b0, "w0_rd08");
    applyStimulus(1, 1'b1, 32'h7C, 32'h13579BDF, 1'b0, 1'b0, 32'h0,        1'b1, "w0_wr7c");
    applyStimulus(1, 1'b1, 32'h3C, 32'h13579BDF, 1'b0, 1'b0, 32'h0,        1'b0, "w0_wr3c");
    applyStimulus(1, 1'b0, 32'h3C, 32'h0,        1'b0, 1'b0, 32'h13579BDF, 1'b0, "w0_rd3c");

    // Three wait states: bus changes during access are ignored.
    applyStimulus(2, 1'b1, 32'h14, 32'h77,       1'b0, 1'b1, 32'h0,        1'b0, "w3_wr14");
    applyStimulus(2, 1'b0, 32'h14, 32'h0,        1'b0, 1'b0, 32'h77,       1'b0, "w3_rd14");
    applyStimulus(2, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, "w3_rd10");

    // PSEL dropped in ACCESS: no response, no write.
    setBus(2, 1'b1, 1'b0, 1'b1, 32'h0C, 32'h55);
    @(posedge clk);
    #1;
    setBus(2, 1'b1, 1'b1, 1'b1, 32'h0C, 32'h55);
    @(posedge clk);
    #1;
    setBus(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    ones = 0;
    repeat (6) begin
      @(negedge clk);
      if (s_ready[2] !== 1'b0 || s_err[2] !== 1'b0) ones++;
    end
    checkOutput("w3_abort_quiet", 32'(ones), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(2, 1'b0, 32'h0C, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, "w3_rd0c");
    applyStimulus(2, 1'b1, 32'h20, 32'hA5,       1'b1, 1'b0, 32'h0,        1'b0, "w3_wr20");
    applyStimulus(2, 1'b0, 32'h20, 32'h0,        1'b0, 1'b0, 32'hA5,       1'b0, "w3_rd20");

    // Reset during the ACCESS phase of a write clears outputs at once and loses the write.
    setBus(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'hAAAA5555);
    @(posedge clk);
    #1;
    setBus(0, 1'b1, 1'b1, 1'b1, 32'h10, 32'hAAAA5555);
    @(posedge clk);
    #2;
    checkOutput("rst_pre_ready", 32'(s_ready[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_ready", 32'(s_ready[0]), 32'd0);
    checkOutput("rst_err", 32'(s_err[0]), 32'd0);
    checkOutput("rst_rdata", s_rdata[0], 32'h0);
    setBus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, "rst_rd10");
    applyStimulus(0, 1'b0, 32'h3C, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, "rst_rd3c");
    applyStimulus(0, 1'b0, 32'h08, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, "rst_rd08");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
